// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bus: PC control, instruction-memory read port,
// decoder handshake, jump request and status.
// master = instr_fetch_ctrl, slave = surrounding datapath / control unit.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               start;
    logic               halt;
    logic [ADDR_W-1:0]  pc_value;
    logic               pc_inc;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_data;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               ir_ready;
    logic               jump_req;
    logic [ADDR_W-1:0]  jump_target;
    logic [15:0]        fetch_count;
    logic               fetch_err;

    modport master (
        input  start, halt, pc_value, imem_rdata, imem_valid, ir_ready,
               jump_req, jump_target,
        output pc_inc, pc_load, pc_load_data, imem_addr, imem_rd_en,
               ir_out, ir_valid, fetch_count, fetch_err
    );

    modport slave (
        output start, halt, pc_value, imem_rdata, imem_valid, ir_ready,
               jump_req, jump_target,
        input  pc_inc, pc_load, pc_load_data, imem_addr, imem_rd_en,
               ir_out, ir_valid, fetch_count, fetch_err
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: reads imem at the current PC, holds the
// word in the instruction register until the decoder takes it, bumps the
// PC, and services jump requests by flushing any in-flight read and loading
// the PC with the latched target.
// Optional build macro: FETCH_TIMEOUT_EN adds a WAIT/FLUSH timeout that sets
// a sticky fetch_err and returns to IDLE.
module instr_fetch_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int INSTR_W        = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_ctrl_if.master  bus
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FLUSH, JUMP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               irv_q, irv_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               pc_inc, pc_load, rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               timeout;
    logic               start_block;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle spent waiting for data.
    assign timeout     = (state_q inside {WAIT, FLUSH}) && !bus.imem_valid &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign start_block = err_q;
    assign bus.fetch_err = err_q;

    // Wait-cycle counter restarts on every state change, sticky error flag.
    always_comb begin
        tmo_d = '0;
        err_d = err_q | timeout;
        if ((state_d == state_q) && (state_q inside {WAIT, FLUSH}))
            tmo_d = tmo_q + TMO_W'(1);
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout       = 1'b0;
    assign start_block   = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    // Next-state, pulse outputs and register updates for the fetch FSM.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        ir_d     = ir_q;
        irv_d    = irv_q;
        cnt_d    = cnt_q;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.halt && !start_block) state_d = REQ;
            end
            REQ: begin
                rd_en   = 1'b1;
                rd_addr = bus.pc_value;
                if (bus.jump_req) begin
                    // read already issued: its response must be drained
                    target_d = bus.jump_target;
                    state_d  = FLUSH;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (timeout) begin
                    irv_d   = 1'b0;
                    state_d = IDLE;
                end else if (bus.jump_req) begin
                    target_d = bus.jump_target;
                    state_d  = bus.imem_valid ? JUMP : FLUSH;
                end else if (bus.imem_valid) begin
                    ir_d    = bus.imem_rdata;
                    irv_d   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = HOLD;
                end
            end
            FLUSH: begin
                if (timeout) begin
                    irv_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (bus.jump_req) target_d = bus.jump_target;
                    if (bus.imem_valid) state_d = JUMP;
                end
            end
            JUMP: begin
                pc_load = 1'b1;
                state_d = bus.halt ? IDLE : REQ;
            end
            HOLD: begin
                if (bus.jump_req) begin
                    irv_d    = 1'b0;
                    target_d = bus.jump_target;
                    state_d  = JUMP;
                end else if (bus.ir_ready) begin
                    irv_d   = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = bus.halt ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            ir_q     <= '0;
            irv_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            ir_q     <= ir_d;
            irv_q    <= irv_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.pc_inc       = pc_inc;
    assign bus.pc_load      = pc_load;
    assign bus.pc_load_data = target_q;
    assign bus.imem_addr    = rd_addr;
    assign bus.imem_rd_en   = rd_en;
    assign bus.ir_out       = ir_q;
    assign bus.ir_valid     = irv_q;
    assign bus.fetch_count  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: PC register and instruction-memory models,
// scoreboard queues of expected fetch addresses, instructions and PC loads,
// with monitors comparing whenever the DUT presents a request/handshake/load.
module tb_instr_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_ctrl_if #(.ADDR_W(16), .INSTR_W(16)) bus();

    instr_fetch_ctrl #(
        .ADDR_W(16),
        .INSTR_W(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned inc_cnt = 0;

    logic [15:0] exp_addr[$];
    logic [15:0] exp_ir[$];
    logic [15:0] exp_load[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
    endtask

    // ---------------- environment models ----------------
    function automatic logic [15:0] mem_data(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0001: return 16'h2222;
            16'h0002: return 16'h3333;
            16'h0003: return 16'h4444;
            16'h0004: return 16'h5555;
            16'h0040: return 16'hABCD;
            16'h0041: return 16'hBEEF;
            16'h0100: return 16'hC0DE;
            16'h0101: return 16'hD00D;
            16'hFFFF: return 16'h7E57;
            default:  return 16'hDEAD;
        endcase
    endfunction

    logic [15:0] pc_q = '0;
    assign bus.pc_value = pc_q;

    always @(posedge clk) begin
        if (rst)              pc_q <= '0;
        else if (bus.pc_load) pc_q <= bus.pc_load_data;
        else if (bus.pc_inc)  pc_q <= pc_q + 16'd1;
    end

    int unsigned lat = 1;
    bit          mem_mute = 1'b0;
    logic        pend = 1'b0;
    int unsigned mcnt = 0;
    logic [15:0] paddr = '0;

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
    end

    always @(posedge clk) begin
        bus.imem_valid <= 1'b0;
        if (pend) begin
            if (mcnt == 1) begin
                bus.imem_valid <= 1'b1;
                bus.imem_rdata <= mem_data(paddr);
                pend <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
        if (bus.imem_rd_en && !mem_mute) begin
            if (lat == 1) begin
                bus.imem_valid <= 1'b1;
                bus.imem_rdata <= mem_data(bus.imem_addr);
            end else begin
                pend  <= 1'b1;
                mcnt  <= lat - 1;
                paddr <= bus.imem_addr;
            end
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (bus.imem_rd_en) begin
            if (exp_addr.size() == 0) fail_now("rd_en_unexpected", {16'h0, bus.imem_addr});
            else check("imem_addr", {16'h0, bus.imem_addr}, {16'h0, exp_addr.pop_front()});
        end
        if (bus.ir_valid && bus.ir_ready && !bus.jump_req) begin
            if (exp_ir.size() == 0) fail_now("ir_handshake_unexpected", {16'h0, bus.ir_out});
            else check("ir_out", {16'h0, bus.ir_out}, {16'h0, exp_ir.pop_front()});
        end
        if (bus.pc_load) begin
            if (exp_load.size() == 0) fail_now("pc_load_unexpected", {16'h0, bus.pc_load_data});
            else check("pc_load_data", {16'h0, bus.pc_load_data}, {16'h0, exp_load.pop_front()});
            check("inc_with_load", {31'h0, bus.pc_inc}, 32'h0);
        end
        if (bus.pc_inc) inc_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] n);
        for (int i = 0; i < 60; i++) begin
            if (bus.fetch_count == n) break;
            cyc();
        end
        check("wait_fetch_count", {16'h0, bus.fetch_count}, {16'h0, n});
    endtask

    task automatic wait_irv();
        for (int i = 0; i < 60; i++) begin
            if (bus.ir_valid) break;
            cyc();
        end
        check("wait_ir_valid", {31'h0, bus.ir_valid}, 32'h1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {27'h0, bus.pc_inc, bus.pc_load, bus.imem_rd_en, bus.ir_valid, bus.fetch_err}, 32'h0);
        check({name, "_data"}, {bus.pc_load_data, bus.imem_addr}, 32'h0);
        check({name, "_ir_cnt"}, {bus.ir_out, bus.fetch_count}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.start       = 1'b0;
        bus.halt        = 1'b0;
        bus.ir_ready    = 1'b1;
        bus.jump_req    = 1'b0;
        bus.jump_target = '0;

        // reset state
        rst = 1'b1;
        cyc(); cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // sequential fetch, 1-cycle memory, decoder always ready
        exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001); exp_addr.push_back(16'h0002);
        exp_ir.push_back(16'h1111);   exp_ir.push_back(16'h2222);   exp_ir.push_back(16'h3333);
        pulse_start();
        wait_cnt(16'd2);
        bus.halt = 1'b1;
        wait_cnt(16'd3);
        repeat (3) cyc();
        check("seq_count", {16'h0, bus.fetch_count}, 32'd3);
        check("seq_inc", inc_cnt, 32'd3);
        check("seq_pc", {16'h0, bus.pc_value}, 32'h3);

        // backpressure in HOLD, halt applied on the handshake
        bus.halt = 1'b0;
        bus.ir_ready = 1'b0;
        exp_addr.push_back(16'h0003);
        exp_ir.push_back(16'h4444);
        pulse_start();
        wait_irv();
        for (int i = 0; i < 5; i++) begin
            check("bp_ir_valid", {31'h0, bus.ir_valid}, 32'h1);
            check("bp_ir_out", {16'h0, bus.ir_out}, 32'h4444);
            check("bp_rd_en", {31'h0, bus.imem_rd_en}, 32'h0);
            cyc();
        end
        bus.halt = 1'b1;
        bus.ir_ready = 1'b1;
        cyc();
        check("bp_count", {16'h0, bus.fetch_count}, 32'd4);
        check("bp_ir_valid_drop", {31'h0, bus.ir_valid}, 32'h0);
        repeat (3) cyc();

        // jump in HOLD, same-cycle handshake cancelled
        bus.halt = 1'b0;
        bus.ir_ready = 1'b0;
        exp_addr.push_back(16'h0004);
        pulse_start();
        wait_irv();
        bus.jump_req = 1'b1;
        bus.jump_target = 16'h0040;
        bus.ir_ready = 1'b1;
        exp_load.push_back(16'h0040);
        exp_addr.push_back(16'h0040);
        exp_ir.push_back(16'hABCD);
        cyc();
        bus.jump_req = 1'b0;
        check("jh_ir_valid", {31'h0, bus.ir_valid}, 32'h0);
        check("jh_pc_load", {31'h0, bus.pc_load}, 32'h1);
        check("jh_count", {16'h0, bus.fetch_count}, 32'd4);
        cyc();
        bus.halt = 1'b1;
        wait_cnt(16'd5);
        repeat (2) cyc();

        // jump_req ignored in IDLE
        bus.jump_req = 1'b1;
        bus.jump_target = 16'h1234;
        cyc();
        bus.jump_req = 1'b0;
        check("idle_jump_load", {31'h0, bus.pc_load}, 32'h0);
        check("idle_jump_target", {16'h0, bus.pc_load_data}, 32'h0040);
        cyc();

        // jump colliding with imem_valid in WAIT
        bus.halt = 1'b0;
        lat = 1;
        exp_addr.push_back(16'h0041);
        pulse_start();
        check("col_req", {31'h0, bus.imem_rd_en}, 32'h1);
        cyc();
        bus.jump_req = 1'b1;
        bus.jump_target = 16'h0100;
        exp_load.push_back(16'h0100);
        exp_addr.push_back(16'h0100);
        exp_ir.push_back(16'hC0DE);
        cyc();
        bus.jump_req = 1'b0;
        check("col_pc_load", {31'h0, bus.pc_load}, 32'h1);
        check("col_ir_valid", {31'h0, bus.ir_valid}, 32'h0);
        check("col_inc", inc_cnt, 32'd6);
        cyc();
        bus.halt = 1'b1;
        wait_cnt(16'd6);
        repeat (2) cyc();
        check("col_inc_after", inc_cnt, 32'd7);

        // 3-cycle memory, jump before data -> FLUSH, retarget in FLUSH, PC wrap
        bus.halt = 1'b0;
        lat = 3;
        exp_addr.push_back(16'h0101);
        pulse_start();
        cyc();
        bus.jump_req = 1'b1;
        bus.jump_target = 16'h0200;
        cyc();
        bus.jump_target = 16'hFFFF;
        cyc();
        bus.jump_req = 1'b0;
        exp_load.push_back(16'hFFFF);
        exp_addr.push_back(16'hFFFF); exp_addr.push_back(16'h0000);
        exp_ir.push_back(16'h7E57);   exp_ir.push_back(16'h1111);
        cyc();
        check("fl_pc_load", {31'h0, bus.pc_load}, 32'h1);
        check("fl_ir_valid", {31'h0, bus.ir_valid}, 32'h0);
        wait_cnt(16'd7);
        bus.halt = 1'b1;
        wait_cnt(16'd8);
        repeat (2) cyc();
        check("wrap_pc", {16'h0, bus.pc_value}, 32'h1);
        check("wrap_inc", inc_cnt, 32'd9);

        // reset asserted in WAIT, late response must be ignored
        bus.halt = 1'b0;
        lat = 3;
        exp_addr.push_back(16'h0001);
        pulse_start();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_all_zero("rst_wait");
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("rst_late_valid", {31'h0, bus.ir_valid}, 32'h0);
        end

        // memory never responds
        mem_mute = 1'b1;
        exp_addr.push_back(16'h0000);
        pulse_start();
        cyc();
`ifdef FETCH_TIMEOUT_EN
        repeat (7) cyc();
        check("tmo_err_early", {31'h0, bus.fetch_err}, 32'h0);
        cyc();
        check("tmo_err", {31'h0, bus.fetch_err}, 32'h1);
        check("tmo_ir_valid", {31'h0, bus.ir_valid}, 32'h0);
        pulse_start();
        repeat (3) cyc();
        check("tmo_err_sticky", {31'h0, bus.fetch_err}, 32'h1);
`else
        repeat (20) cyc();
        check("no_tmo_err", {31'h0, bus.fetch_err}, 32'h0);
        check("no_tmo_ir_valid", {31'h0, bus.ir_valid}, 32'h0);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mem_mute = 1'b0;
        check("final_err_clear", {31'h0, bus.fetch_err}, 32'h0);
        repeat (2) cyc();

        check("exp_addr_left", exp_addr.size(), 32'd0);
        check("exp_ir_left", exp_ir.size(), 32'd0);
        check("exp_load_left", exp_load.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
